// File: rtl/clock_sched_if.sv
// Request and enable bundle between the CPU-side sequencer and the clock scheduler.
// The signal names match the scheduler's documented port list.
interface clock_sched_if;
  logic       stop_req;
  logic       wake;
  logic       switch_req;
  logic       ppu_ce;
  logic       cpu_ce;
  logic       mcyc_ce;
  logic [1:0] tphase;
  logic       double_speed;
  logic       switch_busy;
  logic       switch_done;

  // Requester side: issues STOP / speed-switch requests and consumes the enables.
  modport master (
    output stop_req, wake, switch_req,
    input  ppu_ce, cpu_ce, mcyc_ce, tphase, double_speed, switch_busy, switch_done
  );

  // Scheduler side.
  modport slave (
    input  stop_req, wake, switch_req,
    output ppu_ce, cpu_ce, mcyc_ce, tphase, double_speed, switch_busy, switch_done
  );
endinterface

// File: rtl/clock_sched.sv
// Clock-enable scheduler: derives the fixed-rate PPU enable and the speed-dependent
// CPU T-cycle / M-cycle enables from one master clock, and sequences STOP freeze/wake
// and the KEY1 speed switch (drain to an M-cycle boundary, pause, toggle speed).
module clock_sched #(
  parameter int SIZE         = 4,
  parameter int DIV_T        = 8,
  parameter int PAUSE_CYCLES = 16,
  parameter int PAUSE_W      = 8
) (
  input  logic          clk_in,
  input  logic          reset_n,
  clock_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_STOPPED = 2'd2,
    ST_PAUSE   = 2'd3
  } state_t;

  localparam logic [SIZE-1:0]    HALF_RELOAD = SIZE'(DIV_T / 2 - 1);
  localparam logic [PAUSE_W-1:0] PAUSE_LAST  = PAUSE_W'(PAUSE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [SIZE-1:0]    half_q, half_d;
  logic               parity_q, parity_d;
  logic               drain_sw_q, drain_sw_d;
  logic [PAUSE_W-1:0] pause_q, pause_d;
  // tcnt is the index of the next T-cycle to issue; tphase_q shows the index of
  // the T-cycle whose cpu_ce is currently high.
  logic [1:0]         tcnt_q, tcnt_d;
  logic [1:0]         tphase_q, tphase_d;
  logic               ppu_q, ppu_d;
  logic               cpu_q, cpu_d;
  logic               mcyc_q, mcyc_d;
  logic               dbl_q, dbl_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic h_tick;
  logic cand_tick;
  logic issue;

  // Half-tick divider, enable generation and FSM next-state logic.
  always_comb begin
    state_d    = state_q;
    drain_sw_d = drain_sw_q;
    pause_d    = pause_q;
    dbl_d      = dbl_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    h_tick   = (half_q == '0);
    half_d   = h_tick ? HALF_RELOAD : half_q - SIZE'(1);
    parity_d = parity_q ^ h_tick;

    // PPU enable never depends on speed or FSM state; the CPU candidate is
    // the same tick at normal speed and every half tick at double speed.
    ppu_d     = h_tick & parity_q;
    cand_tick = dbl_q ? h_tick : (h_tick & parity_q);
    issue     = cand_tick & ((state_q == ST_RUN) | (state_q == ST_DRAIN));

    cpu_d    = issue;
    mcyc_d   = issue & (tcnt_q == 2'd3);
    tcnt_d   = issue ? tcnt_q + 2'd1 : tcnt_q;
    tphase_d = issue ? tcnt_q : ((state_q == ST_STOPPED) ? 2'd0 : tphase_q);

    case (state_q)
      ST_RUN: begin
        // A switch request wins over a simultaneous STOP.
        if (bus.switch_req) begin
          state_d    = ST_DRAIN;
          drain_sw_d = 1'b1;
          busy_d     = 1'b1;
        end else if (bus.stop_req) begin
          state_d    = ST_DRAIN;
          drain_sw_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        // Finish the M-cycle in flight before freezing the CPU.
        if (mcyc_d) begin
          state_d = drain_sw_q ? ST_PAUSE : ST_STOPPED;
          pause_d = '0;
        end
      end
      ST_STOPPED: begin
        if (bus.wake) state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (pause_q == PAUSE_LAST) begin
          pause_d = '0;
          dbl_d   = ~dbl_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_RUN;
        end else begin
          pause_d = pause_q + PAUSE_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      half_q     <= HALF_RELOAD;
      parity_q   <= 1'b0;
      drain_sw_q <= 1'b0;
      pause_q    <= '0;
      tcnt_q     <= 2'd0;
      tphase_q   <= 2'd0;
      ppu_q      <= 1'b0;
      cpu_q      <= 1'b0;
      mcyc_q     <= 1'b0;
      dbl_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      parity_q   <= parity_d;
      drain_sw_q <= drain_sw_d;
      pause_q    <= pause_d;
      tcnt_q     <= tcnt_d;
      tphase_q   <= tphase_d;
      ppu_q      <= ppu_d;
      cpu_q      <= cpu_d;
      mcyc_q     <= mcyc_d;
      dbl_q      <= dbl_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.ppu_ce       = ppu_q;
  assign bus.cpu_ce       = cpu_q;
  assign bus.mcyc_ce      = mcyc_q;
  assign bus.tphase       = tphase_q;
  assign bus.double_speed = dbl_q;
  assign bus.switch_busy  = busy_q;
  assign bus.switch_done  = done_q;

endmodule

// File: tb/tb_clock_sched.sv
// Self-checking bench for clock_sched: directed scenarios plus randomized request
// traffic, compared every cycle against an edge-count based reference model.
module tb_clock_sched;

  localparam int DIV   = 8;
  localparam int HALF  = DIV / 2;
  localparam int PAUSE = 16;

  localparam int M_RUN     = 0;
  localparam int M_DRAIN   = 1;
  localparam int M_STOPPED = 2;
  localparam int M_PAUSE   = 3;

  logic clk_in  = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk_in = ~clk_in;

  clock_sched_if bus ();

  clock_sched #(
    .SIZE        (4),
    .DIV_T       (DIV),
    .PAUSE_CYCLES(PAUSE),
    .PAUSE_W     (8)
  ) dut (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: e counts master edges since reset release; every enable is
  // a divisibility test on e, the CPU gating is a small mode variable.
  int   e        = 0;
  int   m_mode   = M_RUN;
  int   m_t      = 0;
  bit   m_dbl    = 0;
  bit   m_busy   = 0;
  bit   m_for_sw = 0;
  int   m_pend   = 0;
  bit   was_rst  = 0;
  bit   exp_ppu, exp_cpu, exp_mcyc, exp_done;
  int   exp_tph;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  task automatic model_edge(input bit sw, input bit st, input bit wk, input bit rn);
    bit cand;
    if (!rn) begin
      e = 0; m_mode = M_RUN; m_t = 0; m_dbl = 0; m_busy = 0; m_for_sw = 0;
      exp_ppu = 0; exp_cpu = 0; exp_mcyc = 0; exp_done = 0; exp_tph = 0;
      was_rst = 1;
      return;
    end
    was_rst = 0;
    e++;
    exp_ppu  = (e % DIV == 0);
    cand     = m_dbl ? (e % HALF == 0) : (e % DIV == 0);
    exp_cpu  = cand && (m_mode == M_RUN || m_mode == M_DRAIN);
    exp_mcyc = exp_cpu && (m_t == 3);
    exp_tph  = m_t;
    if (exp_cpu) m_t = (m_t + 1) % 4;
    exp_done = 0;
    case (m_mode)
      M_RUN: begin
        if (sw) begin m_mode = M_DRAIN; m_for_sw = 1; m_busy = 1; end
        else if (st) begin m_mode = M_DRAIN; m_for_sw = 0; end
      end
      M_DRAIN: begin
        if (exp_mcyc) begin
          if (m_for_sw) begin m_mode = M_PAUSE; m_pend = e + PAUSE; end
          else m_mode = M_STOPPED;
        end
      end
      M_STOPPED: if (wk) m_mode = M_RUN;
      default: begin
        if (e == m_pend) begin
          m_dbl = !m_dbl; exp_done = 1; m_busy = 0; m_mode = M_RUN;
        end
      end
    endcase
  endtask

  task automatic step(input bit sw, input bit st, input bit wk, input bit rn);
    bus.switch_req = sw;
    bus.stop_req   = st;
    bus.wake       = wk;
    reset_n        = rn;
    if (sw || st || !rn)
      $display("[TB] edge %0d: switch_req=%0d stop_req=%0d wake=%0d reset_n=%0d mode=%0d",
               e + 1, sw, st, wk, rn, m_mode);
    @(posedge clk_in);
    model_edge(sw, st, wk, rn);
    #1;
    check_eq("ppu_ce", 32'(bus.ppu_ce), 32'(exp_ppu));
    check_eq("cpu_ce", 32'(bus.cpu_ce), 32'(exp_cpu));
    check_eq("mcyc_ce", 32'(bus.mcyc_ce), 32'(exp_mcyc));
    check_eq("double_speed", 32'(bus.double_speed), 32'(m_dbl));
    check_eq("switch_busy", 32'(bus.switch_busy), 32'(m_busy));
    check_eq("switch_done", 32'(bus.switch_done), 32'(exp_done));
    if (exp_cpu || was_rst) check_eq("tphase", 32'(bus.tphase), 32'(exp_tph));
  endtask

  task automatic idle(input int n, input bit wk);
    for (int i = 0; i < n; i++) step(0, 0, wk, 1);
  endtask

  initial begin
    bit wk;
    int i;

    bus.switch_req = 0;
    bus.stop_req   = 0;
    bus.wake       = 0;

    // Reset and free run at normal speed.
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
    idle(256, 0);

    // Speed switch requested while tphase==1 is on the bus.
    for (i = 0; i < 100 && !(exp_cpu && exp_tph == 1); i++) step(0, 0, 0, 1);
    check_eq("wait_tphase1", 32'(exp_cpu && exp_tph == 1), 32'd1);
    step(1, 0, 0, 1);
    idle(160, 0);

    // Switch back to normal speed.
    step(1, 0, 0, 1);
    idle(160, 0);

    // STOP, stay frozen, then wake.
    step(0, 1, 0, 1);
    idle(100, 0);
    check_eq("stopped_mode", 32'(m_mode), M_STOPPED);
    idle(40, 1);
    idle(20, 0);

    // Simultaneous stop and switch; a stop during the pause is ignored.
    step(1, 1, 0, 1);
    for (i = 0; i < 100 && m_mode != M_PAUSE; i++) step(0, 0, 0, 1);
    check_eq("reach_pause", 32'(m_mode), M_PAUSE);
    idle(3, 0);
    step(0, 1, 0, 1);
    idle(80, 0);

    // Reset in the middle of a double-speed -> normal switch pause.
    step(1, 0, 0, 1);
    for (i = 0; i < 100 && m_mode != M_PAUSE; i++) step(0, 0, 0, 1);
    check_eq("reach_pause2", 32'(m_mode), M_PAUSE);
    idle(7, 0);
    step(0, 0, 0, 0);
    idle(40, 0);

    // Randomized request traffic.
    wk = 0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(59, 0) == 0) wk = !wk;
      step($urandom_range(199, 0) == 0, $urandom_range(149, 0) == 0, wk,
           $urandom_range(1999, 0) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
